// File: rtl/instruction_memory_responder_if.sv
// instruction_memory_responder_if: fetch handshake, program-load port and busy
// flag shared between the fetch requesters / host loader (master) and the
// instruction memory responder (slave). Buses are flat per-port vectors.
interface instruction_memory_responder_if #(
    parameter int N_PORTS           = 4,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
);
    logic [N_PORTS-1:0]                   memory_valid;
    logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr;
    logic [N_PORTS-1:0]                   memory_ready;
    logic [N_PORTS*MEMORY_WIDTH-1:0]      memory_data;
    logic                                 load_valid;
    logic [MEMORY_ADDR_WIDTH-1:0]         load_addr;
    logic [MEMORY_WIDTH-1:0]              load_data;
    logic                                 busy;

    modport master (
        output memory_valid, memory_addr, load_valid, load_addr, load_data,
        input  memory_ready, memory_data, busy
    );

    modport slave (
        input  memory_valid, memory_addr, load_valid, load_addr, load_data,
        output memory_ready, memory_data, busy
    );
endinterface

// File: rtl/instruction_memory_responder.sv
// instruction_memory_responder: arbitrates N_PORTS fetch requesters onto one
// synchronous-read instruction RAM; a granted word is returned on the
// granted port's slice exactly one cycle after the grant. A program-load
// write always wins over fetches in the same cycle.
// Build option: define IMR_ROUND_ROBIN_EN for round-robin arbitration;
// left undefined, the lowest requesting index wins (fixed priority).
module instruction_memory_responder #(
    parameter int N_PORTS           = 4,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
) (
    input logic                          clk,
    input logic                          reset,
    instruction_memory_responder_if.slave bus
);
    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int DEPTH = 1 << MEMORY_ADDR_WIDTH;

    logic [MEMORY_WIDTH-1:0]      ram [DEPTH];
    logic [MEMORY_WIDTH-1:0]      ram_q;
    logic [N_PORTS-1:0]           grant;
    logic [PTR_W-1:0]             grant_idx;
    logic                         grant_any;
    logic [MEMORY_ADDR_WIDTH-1:0] rd_addr;
    logic                         rd_valid_q;
    logic [PTR_W-1:0]             rd_port_q;

`ifdef IMR_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr;
    logic [PTR_W:0]   cand;

    // Round-robin pick: first requester at or after ptr, wrapping; loads block all grants.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (!bus.load_valid) begin
            for (int k = 0; k < N_PORTS; k++) begin
                cand = {1'b0, ptr} + (PTR_W+1)'(k);
                if (cand >= (PTR_W+1)'(N_PORTS))
                    cand = cand - (PTR_W+1)'(N_PORTS);
                if (!grant_any && bus.memory_valid[cand[PTR_W-1:0]]) begin
                    grant[cand[PTR_W-1:0]] = 1'b1;
                    grant_idx              = cand[PTR_W-1:0];
                    grant_any              = 1'b1;
                end
            end
        end
    end

    // Pointer moves to the port after the winner; unchanged when nothing is granted.
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (grant_any)
            ptr <= (grant_idx == PTR_W'(N_PORTS-1)) ? '0 : grant_idx + 1'b1;
    end
`else
    // Fixed priority pick: lowest requesting index wins; loads block all grants.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (!bus.load_valid) begin
            for (int k = 0; k < N_PORTS; k++) begin
                if (!grant_any && bus.memory_valid[k]) begin
                    grant[k]  = 1'b1;
                    grant_idx = PTR_W'(k);
                    grant_any = 1'b1;
                end
            end
        end
    end
`endif

    assign bus.memory_ready = grant;
    assign bus.busy         = rd_valid_q;
    assign rd_addr          = bus.memory_addr[int'(grant_idx)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];

    // Single-port RAM: load writes, a granted fetch captures the word into ram_q.
    // Contents are deliberately not reset so a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (bus.load_valid)
            ram[bus.load_addr] <= bus.load_data;
        if (grant_any)
            ram_q <= ram[rd_addr];
    end

    // Track which port owns the data-return cycle; reset discards an in-flight grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_port_q  <= '0;
        end else begin
            rd_valid_q <= grant_any;
            if (grant_any)
                rd_port_q <= grant_idx;
        end
    end

    // Steer the RAM word onto the owning slice only; every other slice reads zero.
    always_comb begin
        bus.memory_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (rd_valid_q && rd_port_q == PTR_W'(i))
                bus.memory_data[i*MEMORY_WIDTH +: MEMORY_WIDTH] = ram_q;
        end
    end
endmodule
